// File: rtl/second_counter_if.sv
// Control and status bundle between the mode controller / minute stage and second_counter.
// The design side uses the slave modport; the driver side uses master.
interface second_counter_if;
    logic [4:0]  state;
    logic        is_modify;
    logic        i_plus;
    logic        i_minus;
    logic        o_enable;
    logic [14:0] o_second;

    modport master (
        output state,
        output is_modify,
        output i_plus,
        output i_minus,
        input  o_enable,
        input  o_second
    );

    modport slave (
        input  state,
        input  is_modify,
        input  i_plus,
        input  i_minus,
        output o_enable,
        output o_second
    );
endinterface

// File: rtl/second_counter.sv
// Seconds stage: prescales the 1 ms clock to 1 s ticks, counts 0-59, carries on a tick wrap.
// Optional SECOND_MODIFY_PAUSE_EN freezes the prescaler while the seconds field is being edited.
module second_counter #(
    parameter int unsigned TICKS_PER_SEC = 1000,
    parameter logic [4:0]  SEL_STATE     = 5'd0
) (
    input logic               i_clk_0_001s,
    input logic               reset,
    second_counter_if.slave   bus
);

    localparam logic [9:0] LastTick = 10'(TICKS_PER_SEC - 1);
    localparam logic [5:0] MaxSec   = 6'd59;

    logic [9:0] presc_q, presc_d;
    logic       plus_q, minus_q;
    logic       plus_fall_q, minus_fall_q;
    logic [5:0] sec_q, sec_d;
    logic       en_q, en_d;
    logic       edit;
    logic       tick;

    always_comb begin
        edit = bus.is_modify && (bus.state == SEL_STATE);
`ifdef SECOND_MODIFY_PAUSE_EN
        tick    = !edit && (presc_q == LastTick);
        presc_d = (edit || tick) ? 10'd0 : presc_q + 10'd1;
`else
        tick    = (presc_q == LastTick);
        presc_d = tick ? 10'd0 : presc_q + 10'd1;
`endif
        sec_d = sec_q;
        en_d  = 1'b0;
        // Edits pre-empt a coincident tick; only tick wraps carry into the minute stage.
        if (edit && minus_fall_q) begin
            sec_d = (sec_q == 6'd0) ? MaxSec : sec_q - 6'd1;
        end else if (edit && plus_fall_q) begin
            sec_d = (sec_q == MaxSec) ? 6'd0 : sec_q + 6'd1;
        end else if (tick) begin
            if (sec_q == MaxSec) begin
                sec_d = 6'd0;
                en_d  = 1'b1;
            end else begin
                sec_d = sec_q + 6'd1;
            end
        end
    end

    always_ff @(posedge i_clk_0_001s or negedge reset) begin
        if (!reset) begin
            presc_q      <= 10'd0;
            plus_q       <= 1'b0;
            minus_q      <= 1'b0;
            plus_fall_q  <= 1'b0;
            minus_fall_q <= 1'b0;
            sec_q        <= 6'd0;
            en_q         <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            plus_q       <= bus.i_plus;
            minus_q      <= bus.i_minus;
            plus_fall_q  <= plus_q & ~bus.i_plus;
            minus_fall_q <= minus_q & ~bus.i_minus;
            sec_q        <= sec_d;
            en_q         <= en_d;
        end
    end

    assign bus.o_second = {9'd0, sec_q};
    assign bus.o_enable = en_q;

endmodule

// File: tb/tb_second_counter.sv
// Directed self-checking bench for second_counter with TICKS_PER_SEC = 1000.
// Inputs change 1 ns after a rising edge; outputs are sampled at the same point.
`timescale 1ns/1ps
module tb_second_counter;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    int   edges;
    logic en_seen;

    second_counter_if bus ();

    second_counter #(
        .TICKS_PER_SEC(1000),
        .SEL_STATE    (5'd0)
    ) dut (
        .i_clk_0_001s(clk),
        .reset       (reset),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        edges = edges + 1;
        if (bus.o_enable === 1'b1) en_seen = 1'b1;
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic step_to(input int n);
        while (edges < n) step();
    endtask

    task automatic do_reset();
        bus.state     = 5'd0;
        bus.is_modify = 1'b0;
        bus.i_plus    = 1'b0;
        bus.i_minus   = 1'b0;
        reset = 1'b0;
        step_n(2);
        reset   = 1'b1;
        edges   = 0;
        en_seen = 1'b0;
    endtask

    task automatic press_plus(input int n);
        for (int i = 0; i < n; i++) begin
            bus.i_plus = 1'b1;
            step();
            bus.i_plus = 1'b0;
            step();
        end
        step();
    endtask

    task automatic press_minus(input int n);
        for (int i = 0; i < n; i++) begin
            bus.i_minus = 1'b1;
            step();
            bus.i_minus = 1'b0;
            step();
        end
        step();
    endtask

    task automatic test_reset();
        do_reset();
        bus.is_modify = 1'b1;
        press_plus(37);
        bus.is_modify = 1'b0;
        total++;
        if (bus.o_second !== 15'd37) begin
            bad++; $display("FAIL reset_setup: got %0d want 37", bus.o_second);
        end
        reset = 1'b0;
        #1;
        total++;
        if (bus.o_second !== 15'd0) begin
            bad++; $display("FAIL reset_async_sec: got %0d want 0", bus.o_second);
        end
        total++;
        if (bus.o_enable !== 1'b0) begin
            bad++; $display("FAIL reset_async_en: got %b want 0", bus.o_enable);
        end
        step();
        reset = 1'b1;
        edges = 0;
        step_n(999);
        total++;
        if (bus.o_second !== 15'd0) begin
            bad++; $display("FAIL first_tick_999: got %0d want 0", bus.o_second);
        end
        step();
        total++;
        if (bus.o_second !== 15'd1) begin
            bad++; $display("FAIL first_tick_1000: got %0d want 1", bus.o_second);
        end
    endtask

    task automatic test_run_through();
        do_reset();
        step_to(59999);
        total++;
        if (bus.o_second !== 15'd59 || en_seen !== 1'b0) begin
            bad++;
            $display("FAIL run_59: got sec=%0d en_seen=%b want sec=59 en_seen=0",
                     bus.o_second, en_seen);
        end
        step();
        total++;
        if (bus.o_second !== 15'd0 || bus.o_enable !== 1'b1) begin
            bad++;
            $display("FAIL run_wrap: got sec=%0d en=%b want sec=0 en=1",
                     bus.o_second, bus.o_enable);
        end
        step();
        total++;
        if (bus.o_second !== 15'd0 || bus.o_enable !== 1'b0) begin
            bad++;
            $display("FAIL run_after_wrap: got sec=%0d en=%b want sec=0 en=0",
                     bus.o_second, bus.o_enable);
        end
    endtask

    task automatic test_edit_wrap();
        do_reset();
        bus.is_modify = 1'b1;
        bus.state     = 5'd0;
        press_minus(1);
        total++;
        if (bus.o_second !== 15'd59) begin
            bad++; $display("FAIL minus_wrap: got %0d want 59", bus.o_second);
        end
        bus.i_plus = 1'b1;
        step_n(3);
        bus.i_plus = 1'b0;
        step();
        total++;
        if (bus.o_second !== 15'd59) begin
            bad++; $display("FAIL plus_latency: got %0d want 59", bus.o_second);
        end
        step();
        total++;
        if (bus.o_second !== 15'd0) begin
            bad++; $display("FAIL plus_wrap: got %0d want 0", bus.o_second);
        end
        step_n(2);
        total++;
        if (en_seen !== 1'b0) begin
            bad++; $display("FAIL edit_no_carry: got en_seen=%b want 0", en_seen);
        end
        bus.is_modify = 1'b0;
    endtask

    task automatic test_simultaneous();
        do_reset();
        bus.is_modify = 1'b1;
        press_plus(20);
        total++;
        if (bus.o_second !== 15'd20) begin
            bad++; $display("FAIL simul_setup: got %0d want 20", bus.o_second);
        end
        bus.i_plus  = 1'b1;
        bus.i_minus = 1'b1;
        step();
        bus.i_plus  = 1'b0;
        bus.i_minus = 1'b0;
        step_n(2);
        total++;
        if (bus.o_second !== 15'd19) begin
            bad++; $display("FAIL simul_minus_wins: got %0d want 19", bus.o_second);
        end
        step_n(2);
        total++;
        if (bus.o_second !== 15'd19) begin
            bad++; $display("FAIL simul_plus_dropped: got %0d want 19", bus.o_second);
        end
        bus.is_modify = 1'b0;
    endtask

    task automatic test_wrong_field();
        do_reset();
        bus.is_modify = 1'b1;
        bus.state     = 5'd1;
        press_plus(1);
        total++;
        if (bus.o_second !== 15'd0) begin
            bad++; $display("FAIL wrong_field_edit: got %0d want 0", bus.o_second);
        end
        step_to(1000);
        total++;
        if (bus.o_second !== 15'd1) begin
            bad++; $display("FAIL wrong_field_tick: got %0d want 1", bus.o_second);
        end
        bus.is_modify = 1'b0;
        bus.state     = 5'd0;
    endtask

    task automatic test_pause();
        logic [14:0] base;
`ifdef SECOND_MODIFY_PAUSE_EN
        base = 15'd0;
`else
        base = 15'd5;
`endif
        do_reset();
        bus.is_modify = 1'b1;
        step_n(5000);
        total++;
        if (bus.o_second !== base) begin
            bad++; $display("FAIL pause_hold: got %0d want %0d", bus.o_second, base);
        end
        bus.is_modify = 1'b0;
        step_n(999);
        total++;
        if (bus.o_second !== base) begin
            bad++; $display("FAIL pause_resume_999: got %0d want %0d", bus.o_second, base);
        end
        step();
        total++;
        if (bus.o_second !== base + 15'd1) begin
            bad++;
            $display("FAIL pause_resume_1000: got %0d want %0d", bus.o_second, base + 15'd1);
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        edges   = 0;
        en_seen = 1'b0;
        reset   = 1'b0;
        bus.state     = 5'd0;
        bus.is_modify = 1'b0;
        bus.i_plus    = 1'b0;
        bus.i_minus   = 1'b0;
        #2;
        total++;
        if (bus.o_second !== 15'd0 || bus.o_enable !== 1'b0) begin
            bad++;
            $display("FAIL power_on_reset: got sec=%0d en=%b want sec=0 en=0",
                     bus.o_second, bus.o_enable);
        end
        test_reset();
        test_run_through();
        test_edit_wrap();
        test_simultaneous();
        test_wrong_field();
        test_pause();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
